// File: rtl/exe_maint_responder.sv
// exe_maint_responder: arbitrates execute-stage maintenance requests onto the TLB/icache/dcache ports.
module exe_maint_responder #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exe_reset,
  input  logic              tlbcheck_do,
  input  logic [ADDR_W-1:0] tlbcheck_address,
  input  logic              tlbcheck_rw,
  output logic              tlbcheck_done,
  output logic              tlbcheck_page_fault,
  input  logic              tlbflushsingle_do,
  input  logic [ADDR_W-1:0] tlbflushsingle_address,
  output logic              tlbflushsingle_done,
  input  logic              invdcode_do,
  output logic              invdcode_done,
  input  logic              invddata_do,
  output logic              invddata_done,
  input  logic              wbinvddata_do,
  output logic              wbinvddata_done,
  output logic              tlb_op_req,
  output logic              tlb_op_flush,
  output logic [ADDR_W-1:0] tlb_op_address,
  output logic              tlb_op_rw,
  input  logic              tlb_op_ack,
  input  logic              tlb_op_fault,
  output logic              icache_inv_req,
  input  logic              icache_inv_ack,
  output logic              dcache_op_req,
  output logic              dcache_op_writeback,
  input  logic              dcache_op_ack,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  typedef enum logic [2:0] {OP_CHK, OP_FLS, OP_ICI, OP_INV, OP_WBI} op_t;
  state_t state, state_nx;
  op_t op, op_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic rw, rw_nx, abort, abort_nx, fault, fault_nx;
  logic any_do, ack, tlb_sel, issue, fin;
  assign any_do = tlbcheck_do | tlbflushsingle_do | invdcode_do | invddata_do | wbinvddata_do;
  assign tlb_sel = op == OP_CHK || op == OP_FLS;
  // Only the selected target's ack can end the transaction; strays are ignored.
  assign ack = tlb_sel ? tlb_op_ack : op == OP_ICI ? icache_inv_ack : dcache_op_ack;
  always_comb begin
    state_nx = state;
    op_nx = op;
    addr_nx = addr;
    rw_nx = rw;
    abort_nx = abort;
    fault_nx = fault;
    case (state)
      IDLE: if (!exe_reset && any_do) begin
        state_nx = ISSUE;
        abort_nx = 1'b0;
        fault_nx = 1'b0;
        op_nx = wbinvddata_do ? OP_WBI : invddata_do ? OP_INV : invdcode_do ? OP_ICI :
                tlbflushsingle_do ? OP_FLS : OP_CHK;
        addr_nx = (wbinvddata_do | invddata_do | invdcode_do) ? '0 :
                  tlbflushsingle_do ? tlbflushsingle_address : tlbcheck_address;
        rw_nx = op_nx == OP_CHK && tlbcheck_rw;
      end
      ISSUE: begin
        abort_nx = abort | exe_reset;
        if (ack) begin
          state_nx = (abort | exe_reset) ? IDLE : DONE;
          fault_nx = op == OP_CHK && tlb_op_fault;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op <= OP_CHK;
      addr <= '0;
      rw <= 1'b0;
      abort <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_nx;
      op <= op_nx;
      addr <= addr_nx;
      rw <= rw_nx;
      abort <= abort_nx;
      fault <= fault_nx;
    end
  end
  assign issue = state == ISSUE;
  // A flush arriving while the done pulse is due swallows it.
  assign fin = state == DONE && !exe_reset;
  assign tlb_op_req = issue && tlb_sel;
  assign tlb_op_flush = tlb_op_req && op == OP_FLS;
  assign tlb_op_address = addr;
  assign tlb_op_rw = rw;
  assign icache_inv_req = issue && op == OP_ICI;
  assign dcache_op_req = issue && (op == OP_INV || op == OP_WBI);
  assign dcache_op_writeback = dcache_op_req && op == OP_WBI;
  assign tlbcheck_done = fin && op == OP_CHK;
  assign tlbcheck_page_fault = tlbcheck_done && fault;
  assign tlbflushsingle_done = fin && op == OP_FLS;
  assign invdcode_done = fin && op == OP_ICI;
  assign invddata_done = fin && op == OP_INV;
  assign wbinvddata_done = fin && op == OP_WBI;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_exe_maint_responder.sv
// tb_exe_maint_responder: directed stimulus checked against a request-level model every cycle.
module tb_exe_maint_responder;
  localparam int AW = 32;
  logic clk = 0, rst_n = 0, exe_reset = 0;
  logic tlbcheck_do = 0, tlbcheck_rw = 0, tlbcheck_done, tlbcheck_page_fault;
  logic [AW-1:0] tlbcheck_address = '0, tlbflushsingle_address = '0, tlb_op_address;
  logic tlbflushsingle_do = 0, tlbflushsingle_done;
  logic invdcode_do = 0, invdcode_done, invddata_do = 0, invddata_done, wbinvddata_do = 0, wbinvddata_done;
  logic tlb_op_req, tlb_op_flush, tlb_op_rw, tlb_op_ack = 0, tlb_op_fault = 0;
  logic icache_inv_req, icache_inv_ack = 0, dcache_op_req, dcache_op_writeback, dcache_op_ack = 0, busy;
  int tests = 0, fails = 0;

  exe_maint_responder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .exe_reset(exe_reset),
    .tlbcheck_do(tlbcheck_do), .tlbcheck_address(tlbcheck_address), .tlbcheck_rw(tlbcheck_rw),
    .tlbcheck_done(tlbcheck_done), .tlbcheck_page_fault(tlbcheck_page_fault),
    .tlbflushsingle_do(tlbflushsingle_do), .tlbflushsingle_address(tlbflushsingle_address),
    .tlbflushsingle_done(tlbflushsingle_done),
    .invdcode_do(invdcode_do), .invdcode_done(invdcode_done),
    .invddata_do(invddata_do), .invddata_done(invddata_done),
    .wbinvddata_do(wbinvddata_do), .wbinvddata_done(wbinvddata_done),
    .tlb_op_req(tlb_op_req), .tlb_op_flush(tlb_op_flush), .tlb_op_address(tlb_op_address),
    .tlb_op_rw(tlb_op_rw), .tlb_op_ack(tlb_op_ack), .tlb_op_fault(tlb_op_fault),
    .icache_inv_req(icache_inv_req), .icache_inv_ack(icache_inv_ack),
    .dcache_op_req(dcache_op_req), .dcache_op_writeback(dcache_op_writeback),
    .dcache_op_ack(dcache_op_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {tlbcheck_done, tlbcheck_page_fault, tlbflushsingle_done, invdcode_done, invddata_done,
            wbinvddata_done, tlb_op_req, tlb_op_flush, tlb_op_address, tlb_op_rw,
            icache_inv_req, dcache_op_req, dcache_op_writeback, busy};
  endfunction

  // Model: op index 0=tlbcheck 1=tlbflushsingle 2=invdcode 3=invddata 4=wbinvddata (priority rises with index).
  int m_cur = -1, m_done = -1;
  bit m_abort = 0, m_fault = 0, m_rw = 0;
  logic [AW-1:0] m_addr = '0;

  function automatic bit tgt_ack(int o);
    return o < 2 ? tlb_op_ack : o == 2 ? icache_inv_ack : dcache_op_ack;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cur = -1;
      m_done = -1;
      m_abort = 0;
      m_fault = 0;
    end else if (m_done >= 0) m_done = -1;
    else if (m_cur < 0) begin
      logic [4:0] d;
      d = {wbinvddata_do, invddata_do, invdcode_do, tlbflushsingle_do, tlbcheck_do};
      if (!exe_reset)
        for (int k = 4; k >= 0; k--)
          if (d[k] && m_cur < 0) begin
            m_cur = k;
            m_abort = 0;
          end
      if (m_cur == 1) begin m_addr = tlbflushsingle_address; m_rw = 0; end
      if (m_cur == 0) begin m_addr = tlbcheck_address; m_rw = tlbcheck_rw; end
    end else begin
      m_abort |= exe_reset;
      if (tgt_ack(m_cur)) begin
        if (!m_abort) begin
          m_done = m_cur;
          m_fault = m_cur == 0 && tlb_op_fault;
        end
        m_cur = -1;
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] ed;
    logic [11:0] e, a;
    bit tr;
    tr = m_cur == 0 || m_cur == 1;
    for (int k = 0; k < 5; k++) ed[k] = m_done == k && !exe_reset;
    e = {tr, m_cur == 1, m_cur == 2, m_cur >= 3, m_cur == 4, ed, ed[0] && m_fault, m_cur >= 0 || m_done >= 0};
    a = {tlb_op_req, tr && tlb_op_flush, icache_inv_req, dcache_op_req, m_cur >= 3 && dcache_op_writeback,
         wbinvddata_done, invddata_done, invdcode_done, tlbflushsingle_done, tlbcheck_done,
         tlbcheck_done && tlbcheck_page_fault, busy};
    chk("cycle_outputs", a, e);
    if (tr) chk("tlb_addr_rw", {tlb_op_address, tlb_op_rw}, {m_addr, m_rw});
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // which: 0 = TLB, 1 = icache, 2 = dcache; ack pulses dly cycles after the current one.
  task automatic ack_after(int which, int dly, bit f);
    tick(dly);
    if (which == 0) begin tlb_op_ack = 1; tlb_op_fault = f; end
    else if (which == 1) icache_inv_ack = 1;
    else dcache_op_ack = 1;
    tick();
    tlb_op_ack = 0;
    tlb_op_fault = 0;
    icache_inv_ack = 0;
    dcache_op_ack = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tick(2);
    chk("reset_outputs", all_outs(), 0);
    rst_n = 1;
    tick();
    chk("idle_after_reset", all_outs(), 0);
    // tlbcheck with fault, req held three cycles
    tlbcheck_address = 32'h0040_1000;
    tlbcheck_rw = 1;
    tlbcheck_do = 1;
    tick();
    chk("t1_req", {tlb_op_req, tlb_op_flush, tlb_op_rw, tlb_op_address}, {1'b1, 1'b0, 1'b1, 32'h0040_1000});
    ack_after(0, 2, 1);
    chk("t1_done_fault", {tlbcheck_done, tlbcheck_page_fault, tlb_op_req}, 3'b110);
    tlbcheck_do = 0;
    tlbcheck_rw = 0;
    tick();
    chk("t1_after", {tlbcheck_done, busy}, 0);
    // tlbflushsingle acked on the first ISSUE cycle
    tlbflushsingle_address = 32'hFFFF_F000;
    tlbflushsingle_do = 1;
    tick();
    chk("t2_req", {tlb_op_req, tlb_op_flush, tlb_op_rw, tlb_op_address}, {1'b1, 1'b1, 1'b0, 32'hFFFF_F000});
    ack_after(0, 0, 0);
    chk("t2_done", {tlbflushsingle_done, tlb_op_req, busy}, 3'b101);
    tlbflushsingle_do = 0;
    tick();
    chk("t2_idle", busy, 0);
    // simultaneous wbinvd and invdcode
    wbinvddata_do = 1;
    invdcode_do = 1;
    tick();
    chk("t3_wb_first", {dcache_op_req, dcache_op_writeback, icache_inv_req}, 3'b110);
    ack_after(2, 1, 0);
    chk("t3_wb_done", {wbinvddata_done, invdcode_done}, 2'b10);
    wbinvddata_do = 0;
    tick(2);
    chk("t3_ic_req", {icache_inv_req, dcache_op_req}, 2'b10);
    ack_after(1, 0, 0);
    chk("t3_ic_done", {invdcode_done, wbinvddata_done}, 2'b10);
    invdcode_do = 0;
    tick();
    // invddata aborted by exe_reset mid-ISSUE
    invddata_do = 1;
    tick(2);
    exe_reset = 1;
    invddata_do = 0;
    tick();
    exe_reset = 0;
    chk("t4_req_held", {dcache_op_req, dcache_op_writeback, busy}, 3'b101);
    ack_after(2, 4, 0);
    chk("t4_no_done", {invddata_done, busy, dcache_op_req}, 0);
    tick();
    // exe_reset during DONE suppresses the pulse
    tlbcheck_address = 32'h1234_5000;
    tlbcheck_do = 1;
    tick();
    ack_after(0, 0, 1);
    exe_reset = 1;
    #1;
    chk("t5_suppressed", {tlbcheck_done, tlbcheck_page_fault}, 0);
    tlbcheck_do = 0;
    tick();
    exe_reset = 0;
    chk("t5_idle", busy, 0);
    // exe_reset in IDLE blocks acceptance
    exe_reset = 1;
    invdcode_do = 1;
    tick(2);
    chk("t6_blocked", {busy, icache_inv_req}, 0);
    exe_reset = 0;
    tick();
    chk("t6_accepted", icache_inv_req, 1);
    ack_after(1, 0, 0);
    chk("t6_done", invdcode_done, 1);
    invdcode_do = 0;
    tick();
    // stray acks from other targets during a tlbcheck
    tlbcheck_address = 32'h0000_2000;
    tlbcheck_do = 1;
    tick();
    icache_inv_ack = 1;
    dcache_op_ack = 1;
    tick();
    icache_inv_ack = 0;
    dcache_op_ack = 0;
    chk("t7_ignored", {tlb_op_req, tlbcheck_done}, 2'b10);
    ack_after(0, 1, 0);
    chk("t7_done", {tlbcheck_done, tlbcheck_page_fault}, 2'b10);
    tlbcheck_do = 0;
    tick();
    // asynchronous reset mid-ISSUE
    tlbflushsingle_do = 1;
    tick();
    chk("t8_req", tlb_op_req, 1);
    #2 rst_n = 0;
    #1;
    chk("t8_async_clear", all_outs(), 0);
    tlbflushsingle_do = 0;
    #4 rst_n = 1;
    tick(3);
    chk("t8_stays_idle", all_outs(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/exe_maint_responder.md
Name: exe_maint_responder

Overview:
- Serves the maintenance requests that the execute stage raises: tlbcheck, tlbflushsingle, invdcode, invddata and wbinvddata.
- Arbitrates these level-held requests and issues one registered req/ack transaction at a time to the TLB, instruction-cache or data-cache control port.
- Returns a one-cycle done pulse to the execute stage; for tlbcheck, the page-fault result is returned with the pulse.
- Sits between the execute stage and the memory subsystem (TLB, icache, dcache).

Parameters:
ADDR_W, 32, width of the linear address carried by tlbcheck/tlbflushsingle.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
exe_reset  input  1  pipeline flush; aborts reporting of the in-flight request
tlbcheck_do  input  1  level request: check page writability/presence
tlbcheck_address  input  ADDR_W  linear address for tlbcheck
tlbcheck_rw  input  1  1 = write check
tlbcheck_done  output  1  one-cycle completion pulse
tlbcheck_page_fault  output  1  valid only when tlbcheck_done=1
tlbflushsingle_do  input  1  level request: invalidate one TLB entry
tlbflushsingle_address  input  ADDR_W  address to invalidate
tlbflushsingle_done  output  1  completion pulse
invdcode_do  input  1  level request: invalidate icache
invdcode_done  output  1  completion pulse
invddata_do  input  1  level request: invalidate dcache, no writeback
invddata_done  output  1  completion pulse
wbinvddata_do  input  1  level request: writeback then invalidate dcache
wbinvddata_done  output  1  completion pulse
tlb_op_req  output  1  TLB request, held until tlb_op_ack
tlb_op_flush  output  1  0 = check, 1 = flush single
tlb_op_address  output  ADDR_W  latched address
tlb_op_rw  output  1  latched rw (0 when flushing)
tlb_op_ack  input  1  TLB completion, one cycle
tlb_op_fault  input  1  page fault result, sampled with tlb_op_ack
icache_inv_req  output  1  held until icache_inv_ack
icache_inv_ack  input  1  icache completion
dcache_op_req  output  1  held until dcache_op_ack
dcache_op_writeback  output  1  1 = wbinvd, 0 = invd
dcache_op_ack  input  1  dcache completion
busy  output  1  state != IDLE

Behaviour:
- Reset: state=IDLE. All outputs are 0, including every *_done, tlbcheck_page_fault, all downstream req/flag/address outputs, and busy.
- Requests are level-held by the requester until its done pulse. The requester drops do in the cycle after it sees done.
- State IDLE:
  - If exe_reset=0 and any *_do=1, select one request by fixed priority: wbinvddata > invddata > invdcode > tlbflushsingle > tlbcheck.
  - Latch the selected ID, address and rw; go to ISSUE.
  - If exe_reset=1, no request is accepted.
- State ISSUE:
  - The selected downstream req is registered high starting on the first ISSUE cycle.
  - Address, rw, flush and writeback flags are stable for the whole ISSUE state.
  - On the matching ack (the earliest possible is the first ISSUE cycle), drop req in the next cycle and latch fault if the op is tlbcheck.
  - Then go to DONE, or to IDLE if the abort flag is set.
  - An ack from a non-selected target is ignored.
- State DONE: assert exactly the selected *_done for one cycle (tlbcheck_page_fault=latched fault for tlbcheck), then go to IDLE. Requests are not sampled in DONE.
- exe_reset in ISSUE:
  - The downstream transaction is never abandoned; req stays high until ack.
  - Set the abort flag; on ack go to IDLE with no done pulse.
- exe_reset in DONE: the done pulse is suppressed (forced 0); go to IDLE.
- Latency: do sampled in IDLE at cycle T; req=1 at T+1; ack at cycle A≥T+1; done at A+1; next request can be sampled at A+2.
- A do that is dropped while ISSUE is in progress does not cancel the transaction; completion is still reported unless exe_reset is active.
- Simultaneous do lines: the lower-priority request stays pending and is served after the current one (it remains held).
- Async rst_n mid-operation: all state and outputs clear immediately; downstream blocks are reset by the same rst_n.
- At most one downstream req is high at any time; no done pulse without a prior matching ack.

Test Plan:
- tlbcheck_do=1, address=0x0040_1000, rw=1, TLB acks 3 cycles after req with fault=1 -> tlb_op_req high for 3 cycles with tlb_op_address=0x0040_1000, tlb_op_rw=1, flush=0; tlbcheck_done=1 and page_fault=1 for exactly one cycle, one cycle after ack.
- tlbflushsingle_do=1, address=0xFFFF_F000, ack in the same cycle req rises -> req high one cycle, flush=1, rw=0; done two cycles after sampling; busy returns to 0 next cycle.
- wbinvddata_do and invdcode_do asserted in the same cycle -> dcache_op_req with writeback=1 first; after wbinvddata_done and the drop of wbinvddata_do, icache_inv_req issues; two separate done pulses.
- invddata_do=1, exe_reset pulsed 2 cycles into ISSUE, ack 5 cycles later -> dcache_op_req held until ack, invddata_done never asserts, busy=0 after ack.
- rst_n pulled low during ISSUE with tlb_op_req=1 -> all outputs 0 asynchronously; after release with no do, the block stays IDLE and no done appears.
- An icache_inv_ack arrives while a tlbcheck is in ISSUE -> it is ignored; tlbcheck completes only on tlb_op_ack.
